// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the Wishbone memory responder
package wb_pkg;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef enum logic [1:0] {RSP_ACK, RSP_ERR, RSP_RTY} rsp_e;
endpackage

// File: rtl/wishbone_slave_ram.sv
// wishbone_slave_ram: single-port byte-enable RAM with registered read
// Ports: clk, rst (clears only the read register), addr_i word address,
//        be_i per-lane write enables, wdata_i write word, re_i read enable,
//        rdata_o registered read word (holds while re_i is low).
module wishbone_slave_ram
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WB_SELW-1:0]    be_i,
    input  logic [WB_DW-1:0]      wdata_i,
    input  logic                  re_i,
    output logic [WB_DW-1:0]      rdata_o
);
    logic [WB_DW-1:0] mem_q [2**ADDR_WIDTH];
    logic [WB_DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < WB_SELW; i++)
            if (be_i[i])
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (re_i)
            rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/wishbone_slave_mem.sv
// wishbone_slave_mem: Wishbone classic responder over a word-addressed RAM
// Ports: clk, rst (async, active-high); adr/din/sel/we/cyc/stb request from
//        the master; dout/ack/err/rty registered response; wait_states and
//        rty_inject sampled with the request; busy high in WAIT and RESP.
module wishbone_slave_mem
    import wb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        adr,
    input  logic [WB_DW-1:0]   din,
    output logic [WB_DW-1:0]   dout,
    input  logic               cyc,
    input  logic               stb,
    input  logic [WB_SELW-1:0] sel,
    input  logic               we,
    output logic               ack,
    output logic               err,
    output logic               rty,
    input  logic [3:0]         wait_states,
    input  logic               rty_inject,
    output logic               busy
);
    localparam int AW = ADDR_WIDTH;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q;
    logic [31:0]        adr_q;
    logic [WB_DW-1:0]   din_q;
    logic [WB_SELW-1:0] sel_q;
    logic               we_q, inj_q;
    logic               ack_q, err_q, rty_q, busy_q;
    logic [31:0]        req_adr;
    logic [WB_DW-1:0]   req_din;
    logic [WB_SELW-1:0] req_sel;
    logic               req_we, req_inj, take, resp_ack;
    logic [WB_SELW-1:0] ram_be;
    logic               ram_re;
    rsp_e               rsp;

    // A zero-wait request enters RESP on its sampling edge, so the request
    // fields come straight from the bus in IDLE and from the latch otherwise.
    always_comb begin
        req_adr  = state_q == IDLE ? adr : adr_q;
        req_din  = state_q == IDLE ? din : din_q;
        req_sel  = state_q == IDLE ? sel : sel_q;
        req_we   = state_q == IDLE ? we : we_q;
        req_inj  = state_q == IDLE ? rty_inject : inj_q;
        take     = state_q == IDLE && cyc && stb;
        state_d  = take ? (wait_states == 4'd0 ? RESP : WAIT)
                 : state_q == WAIT ? (!cyc ? IDLE : cnt_q == 4'd1 ? RESP : WAIT)
                 : IDLE;
        rsp      = (req_adr[1:0] != 2'b00 || req_adr[31:AW+2] != BASE_ADDR[31:AW+2]) ? RSP_ERR
                 : req_inj ? RSP_RTY : RSP_ACK;
        resp_ack = state_d == RESP && rsp == RSP_ACK;
        ram_be   = resp_ack && req_we ? req_sel : '0;
        ram_re   = resp_ack && !req_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            din_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            inj_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= take ? wait_states : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
            if (take) begin
                adr_q <= adr;
                din_q <= din;
                sel_q <= sel;
                we_q  <= we;
                inj_q <= rty_inject;
            end
            ack_q  <= resp_ack;
            err_q  <= state_d == RESP && rsp == RSP_ERR;
            rty_q  <= state_d == RESP && rsp == RSP_RTY;
            busy_q <= state_d != IDLE;
        end
    end

    wishbone_slave_ram #(.ADDR_WIDTH(AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (req_adr[AW+1:2]),
        .be_i    (ram_be),
        .wdata_i (req_din),
        .re_i    (ram_re),
        .rdata_o (dout)
    );

    assign ack  = ack_q;
    assign err  = err_q;
    assign rty  = rty_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_wishbone_slave_mem.sv
// tb_wishbone_slave_mem: randomized self-checking bench with a memory model
module tb_wishbone_slave_mem;
    localparam int          AW    = 8;
    localparam int          DEPTH = 2**AW;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, din, dout;
    logic        cyc, stb, we, ack, err, rty, rty_inject, busy;
    logic [3:0]  sel, wait_states;

    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_dout;
    int          pass = 0;
    int          total = 0;

    always #5 clk = ~clk;

    wishbone_slave_mem #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .adr(adr), .din(din), .dout(dout), .cyc(cyc),
        .stb(stb), .sel(sel), .we(we), .ack(ack), .err(err), .rty(rty),
        .wait_states(wait_states), .rty_inject(rty_inject), .busy(busy)
    );

    // 1 = ack, 2 = err, 3 = rty
    function automatic int exp_term(input logic [31:0] a, input logic ri);
        if (a % 4 != 0 || a / (4 * DEPTH) != BASE / (4 * DEPTH)) return 2;
        return ri ? 3 : 1;
    endfunction

    task automatic model_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic w, input logic ri);
        int idx;
        idx = int'((a / 4) % DEPTH);
        if (exp_term(a, ri) != 1) return;
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
        end else
            exp_dout = mdl[idx];
    endtask

    // Runs one transfer; term 7 flags more than one termination at once.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input logic [3:0] ws, input logic ri,
                        output int term, output int lat, output int busy_n, output logic [3:0] tail);
        int n;
        term = 0;
        lat = 0;
        busy_n = 0;
        n = 0;
        @(negedge clk);
        adr = a; din = d; sel = s; we = w; wait_states = ws; rty_inject = ri;
        cyc = 1'b1; stb = 1'b1;
        while (term == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (ack || err || rty) begin
                term = int'(ack) + int'(err) + int'(rty) > 1 ? 7 : ack ? 1 : err ? 2 : 3;
                lat = n;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        if (busy) busy_n++;
        tail = {ack, err, rty, busy};
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; din = 0;
        wait_states = 0; rty_inject = 0;
        repeat (3) @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack); else pass++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass++;
        total++; if (rty !== 1'b0) $display("FAIL reset_rty got=%b exp=0", rty); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass++;
        total++; if (dout !== 32'h0) $display("FAIL reset_dout got=%h exp=0", dout); else pass++;
        rst = 1'b0;
        exp_dout = 32'h0;
    endtask

    task automatic test_write_read();
        int t, l, b; logic [3:0] tl;
        xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
        total++; if (t !== 1) $display("FAIL wr_term got=%0d exp=1", t); else pass++;
        total++; if (l !== 1) $display("FAIL wr_latency got=%0d exp=1", l); else pass++;
        total++; if (tl !== 4'b0) $display("FAIL wr_tail got=%b exp=0000", tl); else pass++;
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b0);
        total++; if (t !== 1) $display("FAIL rd_term got=%0d exp=1", t); else pass++;
        total++; if (l !== 1) $display("FAIL rd_latency got=%0d exp=1", l); else pass++;
        total++; if (dout !== 32'hDEADBEEF) $display("FAIL rd_dout got=%h exp=deadbeef", dout); else pass++;
    endtask

    task automatic test_byte_lanes();
        int t, l, b; logic [3:0] tl;
        xfer(32'h10, 32'h11223344, 4'b0101, 1'b1, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h10, 32'h11223344, 4'b0101, 1'b1, 1'b0);
        total++; if (t !== 1) $display("FAIL lane_wr_term got=%0d exp=1", t); else pass++;
        xfer(32'h10, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
        total++; if (dout !== 32'hDE22BE44) $display("FAIL lane_rd_dout got=%h exp=de22be44", dout); else pass++;
        xfer(32'h10, 32'h0, 4'h0, 1'b1, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (t !== 1) $display("FAIL sel0_term got=%0d exp=1", t); else pass++;
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b0);
        total++; if (dout !== exp_dout) $display("FAIL sel0_rd_dout got=%h exp=%h", dout, exp_dout); else pass++;
    endtask

    task automatic test_wait_states();
        int t, l, b; logic [3:0] tl;
        xfer(32'h10, 32'h0, 4'hF, 1'b0, 4'd3, 1'b0, t, l, b, tl);
        model_xfer(32'h10, 32'h0, 4'hF, 1'b0, 1'b0);
        total++; if (t !== 1) $display("FAIL ws3_term got=%0d exp=1", t); else pass++;
        total++; if (l !== 4) $display("FAIL ws3_latency got=%0d exp=4", l); else pass++;
        total++; if (b !== 4) $display("FAIL ws3_busy_cycles got=%0d exp=4", b); else pass++;
        total++; if (tl !== 4'b0) $display("FAIL ws3_one_cycle got=%b exp=0000", tl); else pass++;
        total++; if (dout !== exp_dout) $display("FAIL ws3_dout got=%h exp=%h", dout, exp_dout); else pass++;
    endtask

    task automatic test_err_rty();
        int t, l, b; logic [3:0] tl;
        xfer(32'h0, 32'hA5A50001, 4'hF, 1'b1, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h0, 32'hA5A50001, 4'hF, 1'b1, 1'b0);
        xfer(32'h402, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h402, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
        total++; if (t !== 2) $display("FAIL misalign_term got=%0d exp=2", t); else pass++;
        xfer(32'h0, 32'h0, 4'hF, 1'b0, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
        total++; if (dout !== 32'hA5A50001) $display("FAIL misalign_ram got=%h exp=a5a50001", dout); else pass++;
        xfer(BASE + 4 * DEPTH, 32'h0, 4'hF, 1'b0, 4'd2, 1'b0, t, l, b, tl);
        total++; if (t !== 2) $display("FAIL range_term got=%0d exp=2", t); else pass++;
        total++; if (l !== 3) $display("FAIL range_latency got=%0d exp=3", l); else pass++;
        total++; if (dout !== exp_dout) $display("FAIL err_dout_hold got=%h exp=%h", dout, exp_dout); else pass++;
        xfer(32'h20, 32'h12345678, 4'hF, 1'b1, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h20, 32'h12345678, 4'hF, 1'b1, 1'b0);
        xfer(32'h20, 32'h0, 4'hF, 1'b1, 4'd1, 1'b1, t, l, b, tl);
        model_xfer(32'h20, 32'h0, 4'hF, 1'b1, 1'b1);
        total++; if (t !== 3) $display("FAIL rty_term got=%0d exp=3", t); else pass++;
        xfer(32'h20, 32'h0, 4'hF, 1'b0, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h20, 32'h0, 4'hF, 1'b0, 1'b0);
        total++; if (dout !== 32'h12345678) $display("FAIL rty_ram got=%h exp=12345678", dout); else pass++;
        xfer(32'h21, 32'h0, 4'hF, 1'b0, 4'd0, 1'b1, t, l, b, tl);
        total++; if (t !== 2) $display("FAIL err_priority got=%0d exp=2", t); else pass++;
    endtask

    task automatic test_abort();
        int t, l, b, terms; logic [3:0] tl;
        xfer(32'h30, 32'hCAFE0030, 4'hF, 1'b1, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h30, 32'hCAFE0030, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        adr = 32'h30; din = 32'h0BAD0BAD; sel = 4'hF; we = 1'b1; wait_states = 4'd5; rty_inject = 1'b0;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL abort_busy_wait got=%b exp=1", busy); else pass++;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        terms = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack || err || rty) terms++;
        end
        total++; if (terms !== 0) $display("FAIL abort_terms got=%0d exp=0", terms); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else pass++;
        xfer(32'h30, 32'h0, 4'hF, 1'b0, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h30, 32'h0, 4'hF, 1'b0, 1'b0);
        total++; if (dout !== 32'hCAFE0030) $display("FAIL abort_ram got=%h exp=cafe0030", dout); else pass++;
    endtask

    task automatic test_reset_mid();
        int t, l, b; logic [3:0] tl;
        xfer(32'h34, 32'h00C0FFEE, 4'hF, 1'b1, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h34, 32'h00C0FFEE, 4'hF, 1'b1, 1'b0);
        xfer(32'h30, 32'h0, 4'hF, 1'b0, 4'd0, 1'b0, t, l, b, tl);
        model_xfer(32'h30, 32'h0, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        adr = 32'h34; din = 32'h55555555; sel = 4'hF; we = 1'b1; wait_states = 4'd5; rty_inject = 1'b0;
        cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        #1;
        total++; if ({ack, err, rty, busy} !== 4'b0) $display("FAIL rstmid_outs got=%b exp=0000", {ack, err, rty, busy}); else pass++;
        total++; if (dout !== 32'h0) $display("FAIL rstmid_dout got=%h exp=0", dout); else pass++;
        @(negedge clk);
        rst = 1'b0;
        exp_dout = 32'h0;
        xfer(32'h34, 32'h0, 4'hF, 1'b0, 4'd1, 1'b0, t, l, b, tl);
        model_xfer(32'h34, 32'h0, 4'hF, 1'b0, 1'b0);
        total++; if (t !== 1 || l !== 2) $display("FAIL rstmid_next got=term%0d/lat%0d exp=term1/lat2", t, l); else pass++;
        total++; if (dout !== 32'h00C0FFEE) $display("FAIL rstmid_ram got=%h exp=00c0ffee", dout); else pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] av, bv;
        @(negedge clk);
        adr = 32'h20; din = 32'h0; sel = 4'hF; we = 1'b0; wait_states = 4'd0; rty_inject = 1'b0;
        cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            av[i] = ack;
            bv[i] = busy;
        end
        cyc = 1'b0; stb = 1'b0;
        model_xfer(32'h20, 32'h0, 4'hF, 1'b0, 1'b0);
        total++; if (av !== 6'b010101) $display("FAIL b2b_ack got=%b exp=010101", av); else pass++;
        total++; if (bv !== 6'b010101) $display("FAIL b2b_busy got=%b exp=010101", bv); else pass++;
        total++; if (dout !== exp_dout) $display("FAIL b2b_dout got=%h exp=%h", dout, exp_dout); else pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int t, l, b, et; logic [3:0] tl;
        logic [31:0] a, d; logic [3:0] s, ws; logic w, ri;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            xfer(32'(i * 4), d, 4'hF, 1'b1, 4'($urandom_range(0, 2)), 1'b0, t, l, b, tl);
            model_xfer(32'(i * 4), d, 4'hF, 1'b1, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 7))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = a + 32'(4 * DEPTH);
                default: ;
            endcase
            d = $urandom;
            s = 4'($urandom);
            w = 1'($urandom);
            ws = 4'($urandom_range(0, 3));
            ri = $urandom_range(0, 4) == 0;
            et = exp_term(a, ri);
            xfer(a, d, s, w, ws, ri, t, l, b, tl);
            model_xfer(a, d, s, w, ri);
            total++; if (t !== et) $display("FAIL rnd%0d_term got=%0d exp=%0d", i, t, et); else pass++;
            total++; if (l !== int'(ws) + 1) $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, l, int'(ws) + 1); else pass++;
            total++; if (tl !== 4'b0) $display("FAIL rnd%0d_tail got=%b exp=0000", i, tl); else pass++;
            total++; if (dout !== exp_dout) $display("FAIL rnd%0d_dout got=%h exp=%h", i, dout, exp_dout); else pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wait_states();
        test_err_rty();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/wishbone_slave_mem.md
Name: wishbone_slave_mem

Overview:
Wishbone classic-cycle responder backed by a word-addressed RAM. It is the target end of the bus that our Wishbone master driver initiates on. It is used as the memory or register model in block benches. Wait states are programmable per transfer, and err/rty responses can be injected so the master's handling of all three terminations can be exercised.

Parameters:
ADDR_WIDTH, 8, log2 of RAM depth in 32-bit words (DEPTH = 2**ADDR_WIDTH).
BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to DEPTH*4.

Ports:
clk  input  1  bus clock; all logic on rising edge.
rst  input  1  asynchronous active-high reset.
adr  input  32  byte address from master.
din  input  32  write data from master.
dout  output  32  read data to master.
cyc  input  1  bus cycle valid.
stb  input  1  strobe/transfer request.
sel  input  4  byte lane enables; sel[0] = din[7:0].
we  input  1  1 = write, 0 = read.
ack  output  1  normal termination.
err  output  1  error termination.
rty  output  1  retry termination.
wait_states  input  4  wait cycles inserted before termination; sampled with the request.
rty_inject  input  1  when 1 at request sample, the transfer terminates with rty.
busy  output  1  high in WAIT and RESP states (bench visibility).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset: ack=0, err=0, rty=0, dout=0, busy=0, state=IDLE, wait counter=0. RAM contents are not reset; they are undefined at power-up and preserved across rst.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Samples cyc&stb at each edge.
  - On a sample, latches adr, din, sel, we, rty_inject and wait_states, and loads cnt=wait_states.
  - Goes to RESP if wait_states==0, else to WAIT.
- WAIT:
  - Decrements cnt each edge; at the edge where cnt==1, goes to RESP.
  - If cyc==0 at any WAIT edge, returns to IDLE. This is an abort: no termination, no RAM write.
- RESP:
  - Exactly one cycle. Exactly one of ack/err/rty is high; busy=1.
  - Next edge returns unconditionally to IDLE, so a stb still high in the RESP cycle is not re-sampled.
  - The earliest next request is sampled one edge after RESP ends.
- Latency: request first sampled at edge E -> termination visible in the cycle after edge E+wait_states. Total is wait_states+1 cycles; wait_states=0 gives 1 cycle.
- Termination select, evaluated on the latched request, priority err > rty > ack:
  - err: adr[1:0] != 0, or adr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2].
  - rty: latched rty_inject==1.
  - ack: otherwise.
- Write (ack only): on the edge entering RESP, RAM[adr[ADDR_WIDTH+1:2]] lane i <= din lane i for each sel[i]==1.
  - sel==0 still acks with no change.
  - err and rty never modify RAM.
- Read (ack only): dout is registered on the edge entering RESP with the full word, independent of sel.
  - On err/rty or in any other state, dout holds its last value.
- rst asserted mid-transfer: immediate return to reset values. A pending write is dropped.
- Outputs ack/err/rty/dout are registered, with no combinational path from inputs.

Decomposition:
- Shared package wb_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - response enum {RSP_ACK, RSP_ERR, RSP_RTY};
  - constants WB_DW=32, WB_SELW=4.
- One sub-module: wishbone_slave_ram, a single-port, byte-enable synchronous RAM (write enable per lane, registered read), parameterised by ADDR_WIDTH.

Test Plan:
- Write then read, wait_states=0: write adr=0x10, din=0xDEADBEEF, sel=4'hF -> ack 1 cycle after stb. Read adr=0x10 -> dout=0xDEADBEEF, ack latency 1.
- Byte-lane write: after the above, write adr=0x10, din=0x11223344, sel=4'b0101 -> read returns 0xDE22BE44.
- Wait states: wait_states=3, read adr=0x10 -> ack asserted exactly 4 cycles after stb first sampled, high for one cycle; busy high for those 4 cycles.
- Error and retry:
  - adr=0x402 (misaligned) -> err, RAM unchanged.
  - adr=BASE+4*DEPTH -> err.
  - rty_inject=1 on a write adr=0x20 -> rty, and a following read of 0x20 shows no change.
  - rty_inject=1 on a misaligned address -> err (priority).
- Abort and reset: wait_states=5 write, cyc dropped after 2 cycles -> no termination, RAM unchanged. Separately, rst pulsed during WAIT -> ack/err/rty/busy=0 immediately, state IDLE, next transfer completes normally.
- Back-to-back: master holds stb through the ack cycle -> exactly one termination per transfer; a second request is accepted one cycle after RESP.
